// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and receiver.
package ps2_pkg;

   // Transmitter sequencing states
   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      WAIT_CLK,
      SEND,
      ACK,
      WAIT_IDLE
   } state_t;

   // Command completion status
   typedef enum logic [1:0] {
      ERR_OK     = 2'b00,
      ERR_START  = 2'b01,
      ERR_XFER   = 2'b10,
      ERR_NOACK  = 2'b11
   } err_t;

   localparam int unsigned CNT_W      = 19;
   localparam int unsigned FILT_DEPTH = 4;
   localparam int unsigned FRAME_W    = 10;
   localparam int unsigned IDX_W      = 4;

   // Default timing at a 25.175 MHz pixel clock
   localparam int unsigned DEF_INHIBIT_CYCLES = 2600;
   localparam int unsigned DEF_RTS_CYCLES     = 64;
   localparam int unsigned DEF_START_TIMEOUT  = 378000;
   localparam int unsigned DEF_XFER_TIMEOUT   = 50400;

   localparam logic [7:0] CMD_RESET        = 8'hFF;
   localparam logic [7:0] CMD_ENABLE       = 8'hF4;
   localparam logic [7:0] CMD_SET_DEFAULTS = 8'hF6;

   // Odd parity bit: total number of ones in data plus parity is odd
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   // States belonging to the device-clocked part of the command
   function automatic logic is_xfer(input state_t s);
      return (s == SEND) || (s == ACK) || (s == WAIT_IDLE);
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizer and hysteresis filter for one PS/2 line, with a falling-edge pulse.
module ps2_line_filter
   import ps2_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic fall
);

   logic [1:0]            sync;
   logic [FILT_DEPTH-1:0] hist;

   // Two-flop sync, sample history, level flips only after a full run of equal samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '1;
         hist  <= '1;
         level <= 1'b1;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[0], pin};
         hist <= {hist[FILT_DEPTH-2:0], sync[1]};
         fall <= 1'b0;
         if (level && (hist == '0)) begin
            level <= 1'b0;
            fall  <= 1'b1;
         end else if (!level && (hist == '1)) begin
            level <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift out, ACK check.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int unsigned RTS_CYCLES     = DEF_RTS_CYCLES,
   parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT,
   parameter int unsigned XFER_TIMEOUT   = DEF_XFER_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       rx_inhibit,
   output logic       done,
   output logic [1:0] err
);

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt;
   logic                 cnt_clr;
   logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
   logic                 ack_bad, ack_bad_nxt;
   logic [FRAME_W-1:0]   frame;
   logic                 finish;
   logic [1:0]           err_code;
   logic                 accept;

   logic                 clk_level, clk_fall;
   logic                 data_level, data_fall_unused;

   logic                 tx_ready_nxt, rx_inhibit_nxt, done_nxt;
   logic                 clk_oe_nxt, data_oe_nxt;
   logic [1:0]           err_nxt;

   ps2_line_filter u_clk_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (ps2_clk_in),
      .level (clk_level),
      .fall  (clk_fall)
   );

   ps2_line_filter u_data_filt (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (ps2_data_in),
      .level (data_level),
      .fall  (data_fall_unused)
   );

   assign accept = (state == IDLE) && tx_valid;

   // State, counter, frame and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         ack_bad     <= 1'b0;
         frame       <= '0;
         tx_ready    <= 1'b1;
         rx_inhibit  <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         done        <= 1'b0;
         err         <= ERR_OK;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_clr ? '0 : cnt + CNT_W'(1);
         bit_idx     <= bit_idx_nxt;
         ack_bad     <= ack_bad_nxt;
         if (accept) begin
            frame <= {1'b1, odd_parity(tx_data), tx_data};
         end
         tx_ready    <= tx_ready_nxt;
         rx_inhibit  <= rx_inhibit_nxt;
         ps2_clk_oe  <= clk_oe_nxt;
         ps2_data_oe <= data_oe_nxt;
         done        <= done_nxt;
         err         <= err_nxt;
      end
   end

   // Next-state, bit index, ACK capture and completion detection
   always_comb begin
      state_nxt   = state;
      bit_idx_nxt = bit_idx;
      ack_bad_nxt = ack_bad;
      finish      = 1'b0;
      err_code    = err;
      if (done) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  state_nxt   = INHIBIT;
                  ack_bad_nxt = 1'b0;
               end
            end
            INHIBIT: begin
               if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) state_nxt = RTS;
            end
            RTS: begin
               if (cnt == CNT_W'(RTS_CYCLES - 1)) state_nxt = WAIT_CLK;
            end
            WAIT_CLK: begin
               if (clk_fall) begin
                  state_nxt   = SEND;
                  bit_idx_nxt = '0;
               end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                  finish   = 1'b1;
                  err_code = ERR_START;
               end
            end
            SEND, ACK, WAIT_IDLE: begin
               if (cnt == CNT_W'(XFER_TIMEOUT - 1)) begin
                  finish   = 1'b1;
                  err_code = ack_bad ? ERR_NOACK : ERR_XFER;
               end else if (state == SEND) begin
                  if (clk_fall) begin
                     bit_idx_nxt = bit_idx + IDX_W'(1);
                     if (bit_idx == IDX_W'(FRAME_W - 2)) state_nxt = ACK;
                  end
               end else if (state == ACK) begin
                  if (clk_fall) begin
                     ack_bad_nxt = data_level;
                     state_nxt   = WAIT_IDLE;
                  end
               end else begin
                  if (clk_level && data_level) begin
                     finish   = 1'b1;
                     err_code = ack_bad ? ERR_NOACK : ERR_OK;
                  end
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      // The transfer phase is one timed interval, so the counter keeps running across it
      cnt_clr = (state_nxt == IDLE) ||
                ((state_nxt != state) && !(is_xfer(state) && is_xfer(state_nxt)));
   end

   // Output values for the coming cycle, derived from the next state
   always_comb begin
      tx_ready_nxt   = (state_nxt == IDLE);
      rx_inhibit_nxt = (state_nxt != IDLE);
      done_nxt       = finish;
      err_nxt        = finish ? err_code : err;
      clk_oe_nxt     = 1'b0;
      data_oe_nxt    = 1'b0;
      if (!finish) begin
         case (state_nxt)
            INHIBIT:  clk_oe_nxt = 1'b1;
            RTS: begin
               clk_oe_nxt  = 1'b1;
               data_oe_nxt = 1'b1;
            end
            WAIT_CLK: data_oe_nxt = 1'b1;
            SEND:     data_oe_nxt = ~frame[bit_idx_nxt];
            default:  data_oe_nxt = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized scoreboard bench for ps2_host_tx with a behavioural PS/2 device.
module tb_ps2_host_tx;

   localparam int unsigned INH   = 20;
   localparam int unsigned RTSC  = 6;
   localparam int unsigned ST_TO = 300;
   localparam int unsigned XF_TO = 600;
   localparam int unsigned HALF  = 12;

   localparam int MODE_ACK   = 0;
   localparam int MODE_NACK  = 1;
   localparam int MODE_NOCLK = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       rx_inhibit, done;
   logic [1:0] err;

   logic       dev_clk = 1'b1;
   logic       dev_data = 1'b1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] err;
      logic [7:0] data;
      logic       par;
      logic       has_frame;
   } exp_t;

   exp_t        exp_q[$];
   logic [10:0] cap_q[$];
   exp_t        mon_e;
   logic [10:0] mon_c;
   logic        post_done = 1'b0;

   always #5 clk = ~clk;

   // Open-drain wired-AND of host and device on both lines
   assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .RTS_CYCLES     (RTSC),
      .START_TIMEOUT  (ST_TO),
      .XFER_TIMEOUT   (XF_TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .rx_inhibit  (rx_inhibit),
      .done        (done),
      .err         (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: on every done pulse pop the expected response and compare
   initial begin
      forever begin
         @(negedge clk);
         if (post_done) begin
            post_done = 1'b0;
            chk("after_done_ready", 32'(tx_ready), 32'd1);
            chk("after_done_inhibit", 32'(rx_inhibit), 32'd0);
         end
         if (rst_n && done) begin
            post_done = 1'b1;
            chk("done_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
            if (exp_q.size() == 0) begin
               chk("done_unexpected", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("err", 32'(err), 32'(mon_e.err));
               if (mon_e.has_frame) begin
                  if (cap_q.size() == 0) begin
                     chk("frame_missing", 32'd1, 32'd0);
                  end else begin
                     mon_c = cap_q.pop_front();
                     chk("start_bit", 32'(mon_c[0]), 32'd0);
                     chk("data_bits", 32'(mon_c[8:1]), 32'(mon_e.data));
                     chk("parity_bit", 32'(mon_c[9]), 32'(mon_e.par));
                     chk("stop_bit", 32'(mon_c[10]), 32'd1);
                  end
               end
            end
         end
      end
   end

   // Issue one command and play the device side of the exchange
   task automatic send(input logic [7:0] d, input int mode, input bit abort);
      exp_t        e;
      logic [10:0] cap;
      int          k, n_clk, drise, gap, ones;
      k = 0;
      while (!tx_ready && k < 5000) begin
         @(negedge clk);
         k++;
      end
      chk("ready_wait", 32'(tx_ready), 32'd1);
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      e.data      = d;
      e.par       = ((ones % 2) == 0);
      e.has_frame = (mode != MODE_NOCLK);
      e.err       = (mode == MODE_ACK) ? 2'b00 : (mode == MODE_NACK) ? 2'b11 : 2'b01;
      if (!abort) exp_q.push_back(e);
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      chk("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
      chk("accept_ready", 32'(tx_ready), 32'd0);
      chk("accept_inhibit", 32'(rx_inhibit), 32'd1);
      chk("accept_data_oe", 32'(ps2_data_oe), 32'd0);
      n_clk = 0;
      drise = -1;
      k     = 0;
      while (ps2_clk_oe && k < 1000) begin
         if (ps2_data_oe && drise < 0) drise = k;
         n_clk++;
         k++;
         @(negedge clk);
      end
      chk("clk_oe_len", 32'(n_clk), INH + RTSC);
      chk("data_oe_rise", 32'(drise), INH);
      chk("start_held", 32'(ps2_data_oe), 32'd1);
      if (mode == MODE_NOCLK) begin
         k = 0;
         while (!done && k < int'(ST_TO) + 50) begin
            @(negedge clk);
            k++;
         end
         chk("start_timeout_time", 32'(k), ST_TO);
         return;
      end
      gap = $urandom_range(6, 40);
      repeat (gap / 2) @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (gap / 2) @(negedge clk);
      cap[0] = ps2_data_in;
      for (int b = 1; b <= 11; b++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (b <= 10) cap[b] = ps2_data_in;
         dev_clk = 1'b1;
         if (abort && b == 4) begin
            repeat (3) @(negedge clk);
            #3 rst_n = 1'b0;
            #1;
            chk("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
            chk("reset_data_oe", 32'(ps2_data_oe), 32'd0);
            chk("reset_ready", 32'(tx_ready), 32'd1);
            chk("reset_inhibit", 32'(rx_inhibit), 32'd0);
            dev_data = 1'b1;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            return;
         end
         if (b == 10) begin
            cap_q.push_back(cap);
            if (mode == MODE_ACK) dev_data = 1'b0;
         end
         repeat (HALF) @(negedge clk);
      end
      dev_data = 1'b1;
      k = 0;
      while (!tx_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("finish_wait", 32'(tx_ready), 32'd1);
   endtask

   // Directed commands, error cases, reset abort, then randomized traffic
   initial begin
      int r, mode;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
      chk("rst_inhibit", 32'(rx_inhibit), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      send(8'hF4, MODE_ACK, 1'b0);
      send(8'h00, MODE_ACK, 1'b0);
      send(8'hFF, MODE_ACK, 1'b0);
      send(8'h5A, MODE_NACK, 1'b0);
      send(8'hF6, MODE_NOCLK, 1'b0);
      send(8'($urandom), MODE_ACK, 1'b1);
      send(8'hFF, MODE_ACK, 1'b0);
      for (int i = 0; i < 16; i++) begin
         r    = $urandom_range(0, 9);
         mode = (r < 7) ? MODE_ACK : (r < 9) ? MODE_NACK : MODE_NOCLK;
         send(8'($urandom), mode, 1'b0);
      end
      repeat (20) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
